bus_arbiter: RTL and testbench

Snooping-bus arbiter and transaction sequencer for the MSI multiprocessor. Sits directly upstream of every cache controller: collects per-CPU miss/upgrade requests, grants one requester at a time round-robin, broadcasts the chosen transaction (`bus_msg`, `addr`) to all snooping caches, then models memory latency and returns a one-cycle data-valid pulse to the requester. One transaction in flight at a time.

---
 rtl/msi_pkg.sv | 27 ++
 rtl/bus_arbiter_rr.sv | 30 +++
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// Shared MSI bus definitions: snoop message encoding and the bus arbiter state set.
package msi_pkg;

    typedef enum logic [1:0] {
        BUS_RD    = 2'b00,
        BUS_RDX   = 2'b01,
        BUS_UPGR  = 2'b10,
        BUS_FLUSH = 2'b11
    } bus_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BCAST,
        ARB_WAIT_MEM,
        ARB_DONE
    } arb_state_t;

    // A write miss outranks an upgrade, which outranks a plain read miss.
    function automatic bus_msg_t req_to_msg(input logic wr, input logic upgr);
        if (wr)
            return BUS_RDX;
        else if (upgr)
            return BUS_UPGR;
        return BUS_RD;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// Round-robin pick: scans the request vector starting at ptr and returns the first hit.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant, one-cycle broadcast, memory latency model, completion pulse.
// Optional BUS_ARB_FLUSH_FWD_EN: a Flush from another snooper ends the memory wait early.
//
// state        | meaning
// ARB_IDLE     | no transaction; requests sampled, winner latched
// ARB_BCAST    | bus_valid_o high for one cycle with latched msg/addr
// ARB_WAIT_MEM | memory latency countdown
// ARB_DONE     | data_valid_o pulse to owner, pointer advances
module bus_arbiter
    import msi_pkg::*;
#(
    parameter int NUM_CPUS = 2,
    parameter int ADDR_W   = 2,
    parameter int MEM_LAT  = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CPUS-1:0]        req_rd_i,
    input  logic [NUM_CPUS-1:0]        req_wr_i,
    input  logic [NUM_CPUS-1:0]        req_upgr_i,
    input  logic [NUM_CPUS*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_CPUS-1:0]        flush_i,
    output logic [NUM_CPUS-1:0]        grant_o,
    output logic                       bus_valid_o,
    output logic [1:0]                 bus_msg_o,
    output logic [ADDR_W-1:0]          bus_addr_o,
    output logic [NUM_CPUS-1:0]        data_valid_o
);

    localparam int IDX_W = $clog2(NUM_CPUS);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CPUS - 1);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [IDX_W-1:0]      winner_q, winner_d;
    logic [NUM_CPUS-1:0]   grant_q, grant_d;
    bus_msg_t              msg_q, msg_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_CPUS-1:0]   req_any;
    logic [NUM_CPUS-1:0]   win_onehot;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_valid;
    logic                  flush_hit;
    logic [ADDR_W-1:0]     addr_arr [NUM_CPUS];

    assign req_any = req_rd_i | req_wr_i | req_upgr_i;

    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_addr
        assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    end

    rr_arbiter #(
        .N     (NUM_CPUS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req    (req_any),
        .ptr    (rr_q),
        .grant  (win_onehot),
        .winner (win_idx),
        .valid  (win_valid)
    );

`ifdef BUS_ARB_FLUSH_FWD_EN
    assign flush_hit = |(flush_i & ~grant_q);
`else
    // Forwarding disabled: flush_i is tied off and never affects completion.
    assign flush_hit = 1'b0 & (|flush_i);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            rr_q     <= '0;
            winner_q <= '0;
            grant_q  <= '0;
            msg_q    <= BUS_RD;
            addr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            winner_q <= winner_d;
            grant_q  <= grant_d;
            msg_q    <= msg_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        winner_d = winner_q;
        grant_d  = grant_q;
        msg_d    = msg_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    winner_d = win_idx;
                    grant_d  = win_onehot;
                    msg_d    = req_to_msg(req_wr_i[win_idx], req_upgr_i[win_idx]);
                    addr_d   = addr_arr[win_idx];
                    state_d  = ARB_BCAST;
                end
            end
            ARB_BCAST: begin
                if (msg_q == BUS_UPGR) begin
                    state_d = ARB_DONE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ARB_WAIT_MEM;
                end
            end
            ARB_WAIT_MEM: begin
                if (flush_hit || cnt_q == CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ARB_DONE: begin
                rr_d    = (winner_q == IDX_LAST) ? '0 : winner_q + IDX_W'(1);
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs decode only registered state; msg/addr read as zero outside the broadcast cycle.
    assign bus_valid_o  = (state_q == ARB_BCAST);
    assign grant_o      = (state_q != ARB_IDLE) ? grant_q : '0;
    assign bus_msg_o    = bus_valid_o ? msg_q : BUS_RD;
    assign bus_addr_o   = bus_valid_o ? addr_q : '0;
    assign data_valid_o = (state_q == ARB_DONE) ? grant_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed literal scenarios plus randomized traffic vs. a transaction-timeline model.
module tb_bus_arbiter;

    localparam int N   = 2;
    localparam int AW  = 2;
    localparam int LAT = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [N-1:0]  req_rd_i   = '0;
    logic [N-1:0]  req_wr_i   = '0;
    logic [N-1:0]  req_upgr_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N-1:0]  flush_i    = '0;
    logic [N-1:0]  grant_o;
    logic          bus_valid_o;
    logic [1:0]    bus_msg_o;
    logic [AW-1:0] bus_addr_o;
    logic [N-1:0]  data_valid_o;

    bus_arbiter #(.NUM_CPUS(N), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_rd_i     (req_rd_i),
        .req_wr_i     (req_wr_i),
        .req_upgr_i   (req_upgr_i),
        .req_addr_i   (req_addr_i),
        .flush_i      (flush_i),
        .grant_o      (grant_o),
        .bus_valid_o  (bus_valid_o),
        .bus_msg_o    (bus_msg_o),
        .bus_addr_o   (bus_addr_o),
        .data_valid_o (data_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int total  = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endfunction

    // Transaction-timeline model: each transaction is a winner plus the cycle numbers of its
    // broadcast and completion; outputs follow from comparing the cycle count to those numbers.
    int            cyc = 0;
    bit            in_txn = 1'b0;
    int            rr = 0;
    int            m_owner = 0, m_bcast = 0, m_done = 0;
    logic [1:0]    m_msg = 2'b00;
    logic [AW-1:0] m_addr = '0;
    logic [N-1:0]  m_any;
    bit            found;
    int            wait_cnt [N];
    int            worst_wait = 0;

    logic [N-1:0]  exp_grant = '0, exp_dv = '0;
    logic          exp_bv = 1'b0;
    logic [1:0]    exp_msg = 2'b00;
    logic [AW-1:0] exp_addr = '0;

    assign m_any = req_rd_i | req_wr_i | req_upgr_i;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc    = 0;
            in_txn = 1'b0;
            rr     = 0;
            for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        end else begin
            cyc++;
            if (!in_txn) begin
                if (m_any != '0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && m_any[(rr + k) % N]) begin
                            found   = 1'b1;
                            m_owner = (rr + k) % N;
                        end
                    end
                    m_msg   = req_wr_i[m_owner] ? 2'b01 : (req_upgr_i[m_owner] ? 2'b10 : 2'b00);
                    m_addr  = req_addr_i[m_owner*AW +: AW];
                    m_bcast = cyc;
                    m_done  = (m_msg == 2'b10) ? cyc + 1 : cyc + 1 + LAT;
                    in_txn  = 1'b1;
                    for (int k = 0; k < N; k++) begin
                        if (k == m_owner) wait_cnt[k] = 0;
                        else if (m_any[k]) wait_cnt[k]++;
                        if (wait_cnt[k] > worst_wait) worst_wait = wait_cnt[k];
                    end
                end
            end else if (cyc - 1 == m_done) begin
                in_txn = 1'b0;
                rr     = (m_owner + 1) % N;
            end else begin
`ifdef BUS_ARB_FLUSH_FWD_EN
                for (int k = 0; k < N; k++)
                    if (k != m_owner && flush_i[k] && cyc - 1 > m_bcast && m_msg != 2'b10)
                        m_done = cyc;
`endif
            end
        end
        exp_grant = '0;
        exp_dv    = '0;
        if (in_txn) begin
            exp_grant[m_owner] = 1'b1;
            if (cyc == m_done) exp_dv[m_owner] = 1'b1;
        end
        exp_bv   = in_txn && (cyc == m_bcast);
        exp_msg  = m_msg;
        exp_addr = m_addr;
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("grant", 32'(grant_o), 32'(exp_grant));
            check("bus_valid", 32'(bus_valid_o), 32'(exp_bv));
            check("data_valid", 32'(data_valid_o), 32'(exp_dv));
            if (exp_bv) begin
                check("bus_msg", 32'(bus_msg_o), 32'(exp_msg));
                check("bus_addr", 32'(bus_addr_o), 32'(exp_addr));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_reqs();
        req_rd_i   = '0;
        req_wr_i   = '0;
        req_upgr_i = '0;
        flush_i    = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    bit pend [N];

    initial begin
        #1 rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        #1;
        check("reset_grant", 32'(grant_o), 32'h0);
        check("reset_bus_valid", 32'(bus_valid_o), 32'h0);
        check("reset_msg_addr", 32'({bus_msg_o, bus_addr_o}), 32'h0);
        check("reset_data_valid", 32'(data_valid_o), 32'h0);
        chk_en = 1'b1;

        // CPU0 read miss, addr 2
        do_reset();
        req_rd_i = 2'b01; req_addr_i = {2'd0, 2'd2};
        step();
        check("t1_bus_valid", 32'(bus_valid_o), 32'h1);
        check("t1_msg", 32'(bus_msg_o), 32'h0);
        check("t1_addr", 32'(bus_addr_o), 32'h2);
        check("t1_grant", 32'(grant_o), 32'h1);
        step(); step(); step();
        check("t1_dv_c4", 32'(data_valid_o), 32'h0);
        step();
        check("t1_dv_c5", 32'(data_valid_o), 32'h1);
        clear_reqs();
        step();
        check("t1_idle_grant", 32'(grant_o), 32'h0);

        // CPU1 read+write together, addr 1 -> BusRdX
        req_rd_i = 2'b10; req_wr_i = 2'b10; req_addr_i = {2'd1, 2'd0};
        step();
        check("t2_msg", 32'(bus_msg_o), 32'h1);
        check("t2_addr", 32'(bus_addr_o), 32'h1);
        check("t2_grant", 32'(grant_o), 32'h2);
        step(); step(); step();
        check("t2_dv_c4", 32'(data_valid_o), 32'h0);
        step();
        check("t2_dv_c5", 32'(data_valid_o), 32'h2);
        clear_reqs();
        step();

        // CPU0 upgrade, addr 3
        req_upgr_i = 2'b01; req_addr_i = {2'd0, 2'd3};
        step();
        check("t3_msg", 32'(bus_msg_o), 32'h2);
        check("t3_addr", 32'(bus_addr_o), 32'h3);
        step();
        check("t3_dv_c2", 32'(data_valid_o), 32'h1);
        check("t3_no_bcast_c2", 32'(bus_valid_o), 32'h0);
        clear_reqs();
        step();

        // both CPUs requesting continuously from reset
        do_reset();
        req_rd_i = 2'b11; req_addr_i = {2'd3, 2'd1};
        step();
        for (int k = 0; k < 4; k++) begin
            check("t4_alt_grant", 32'(grant_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("t4_alt_bcast", 32'(bus_valid_o), 32'h1);
            if (k < 3) repeat (6) step();
        end
        clear_reqs();
        repeat (6) step();

        // flush from the other CPU in the first WAIT_MEM cycle
        do_reset();
        req_rd_i = 2'b01; req_addr_i = {2'd0, 2'd1};
        step(); step();
        flush_i = 2'b10;
        step();
        flush_i = 2'b00;
`ifdef BUS_ARB_FLUSH_FWD_EN
        check("t5_dv_c3", 32'(data_valid_o), 32'h1);
        clear_reqs();
        step(); step();
        check("t5_idle_c5", 32'(grant_o), 32'h0);
`else
        check("t5_dv_c3", 32'(data_valid_o), 32'h0);
        step(); step();
        check("t5_dv_c5", 32'(data_valid_o), 32'h1);
        clear_reqs();
`endif
        step(); step();

        // reset pulsed during WAIT_MEM
        do_reset();
        req_rd_i = 2'b01; req_addr_i = {2'd0, 2'd2};
        step(); step(); step();
        rst_i = 1'b1;
        #1;
        check("t6_rst_grant", 32'(grant_o), 32'h0);
        check("t6_rst_dv_bv", 32'({data_valid_o, bus_valid_o}), 32'h0);
        step();
        rst_i = 1'b0;
        step();
        check("t6_regrant", 32'(grant_o), 32'h1);
        check("t6_rebcast", 32'(bus_valid_o), 32'h1);
        repeat (4) step();
        check("t6_dv", 32'(data_valid_o), 32'h1);
        clear_reqs();
        step();

        // randomized traffic; each requester holds until its completion pulse
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && data_valid_o[i]) begin
                    req_rd_i[i] = 1'b0; req_wr_i[i] = 1'b0; req_upgr_i[i] = 1'b0;
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 4))
                        0: req_rd_i[i] = 1'b1;
                        1: req_wr_i[i] = 1'b1;
                        2: req_upgr_i[i] = 1'b1;
                        3: begin req_rd_i[i] = 1'b1; req_wr_i[i] = 1'b1; end
                        default: begin req_rd_i[i] = 1'b1; req_upgr_i[i] = 1'b1; end
                    endcase
                    req_addr_i[i*AW +: AW] = AW'($urandom);
                    pend[i] = 1'b1;
                end
            end
            flush_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step();
        end
        check("no_starvation", 32'(worst_wait <= N - 1), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
